drag_tree_ctrl: RTL and testbench
=================================

Name: drag_tree_ctrl

Overview:
Parametrised drag-race "christmas tree" controller for N lanes, the next-generation replacement for the single-lane tree FSM. It samples per-lane pre-stage and stage beams and holds a staging interval with an internal counter, replacing the external LPM counter. It then runs a shared amber countdown in either full-tree or pro-tree mode, and latches a per-lane green or red (foul) result. It drives the lamp decoders (HEX lights) at the board top level.

Parameters:
LANES, 2, number of racing lanes (1..8)
AMBERS, 3, number of amber lamps in the tree (1..4)
STAGE_CYCLES, 50000000, cycles all lanes must stay staged before the countdown starts
STEP_CYCLES, 25000000, cycles each amber step is lit
CNT_W, 26, width of the interval counter; must hold max(STAGE_CYCLES, STEP_CYCLES)-1

Ports:
Clock  in  1  system clock (CLOCK_50)
Rst  in  1  asynchronous, active-low reset
ProMode  in  1  0 = full tree (ambers one at a time), 1 = pro tree (all ambers together); sampled only in IDLE
NewRace  in  1  synchronous request to return from DONE to IDLE
PSB  in  LANES  pre-stage beam per lane, 1 = broken
SB  in  LANES  stage beam per lane, 1 = broken
PSL  out  LANES  pre-stage lamp per lane
SL  out  LANES  stage lamp per lane
AMB  out  AMBERS  shared amber lamps; AMB[0] is top
GRN  out  LANES  green lamp per lane
RED  out  LANES  red (foul) lamp per lane
Done  out  1  race result latched

Behaviour:
- Reset while Rst=0, asynchronous: state=IDLE; counter, step index, mode latch, foul mask all 0; every output 0.
- PSL and SL are registered copies of PSB and SB with 1-cycle latency in every state.
- State IDLE:
  - ProMode is latched each cycle.
  - When SB is all 1s, go to STAGE with counter=0.
- State STAGE:
  - If any SB bit is 0, go to IDLE; the counter is discarded.
  - Otherwise the counter increments each cycle.
  - When counter==STAGE_CYCLES-1, go to AMBER with step=0 and counter=0. STAGE therefore lasts exactly STAGE_CYCLES cycles.
- State AMBER:
  - Full tree: AMB has only bit [step] set. Each step lasts STEP_CYCLES cycles; after step AMBERS-1 completes, go to GREEN.
  - Pro tree: all AMB bits are 1 for one step of STEP_CYCLES cycles, then go to GREEN.
  - Foul: any lane whose SB is 0 in any AMBER cycle sets its foul bit, and RED[l]=1 from the next cycle.
  - Fouls are sticky; the lane's later SB value is ignored.
  - If all lanes are fouled, go to DONE immediately (next cycle) and AMB clears.
- State GREEN (1 cycle):
  - GRN[l]=1 for every non-fouled lane; AMB=0.
  - Go to DONE.
- State DONE:
  - GRN and RED hold.
  - When NewRace=1, go to IDLE next cycle with GRN, RED and the foul mask cleared.
  - NewRace is ignored in all other states.
- Done=1 in GREEN and DONE.
- Simultaneous events:
  - An SB drop on the final amber cycle counts as a foul; that lane gets RED, never GRN.
  - Mode change during a race has no effect until the next IDLE.
- Reset mid-race returns to IDLE asynchronously; no lamps persist.
- Counter compare is equality on CNT_W bits and does not wrap.

Optional Feature:
Macro DRAG_REACTION_TIMER_EN.
- With it defined:
  - Adds output React of width LANES*CNT_W, one field per lane.
  - Each field counts cycles from GREEN until the lane's SB first falls, then freezes.
  - It saturates at all-ones and clears on NewRace or reset.
  - Fouled lanes read 0.
  - Adds output Winner of width LANES, one-hot: the first non-fouled lane to drop SB. Ties go to the lowest index.
- Without it: no React or Winner ports and no associated logic.

Decomposition:
- Shared package drag_pkg holds:
  - the state encoding localparams IDLE, STAGE, AMBER, GREEN, DONE (3 bits);
  - the mode constants FULL_TREE=0 and PRO_TREE=1.
- One sub-module, drag_interval_timer: parametrised CNT_W up-counter with synchronous clear, enable, and a terminal-count compare input. It is instantiated once and shared by STAGE and AMBER.

Test Plan (LANES=2, AMBERS=3, STAGE_CYCLES=8, STEP_CYCLES=4):
- Full tree, clean start: ProMode=0, SB=11 from cycle 0 → AMB=001,010,100 for 4 cycles each starting at cycle 9; GRN=11 and Done=1 at cycle 21.
- Pro tree: ProMode=1, SB=11 → AMB=111 for cycles 9-12; GRN=11 at cycle 13.
- Staging abort: SB=11 for 5 cycles, then SB[1]=0 → back to IDLE, AMB stays 000; re-staging restarts the full 8-cycle count.
- Single foul: SB[0] drops during amber step 1 → RED=01 next cycle; tree continues; at the end GRN=10 and RED=01.
- Double foul and restart: both SB drop in AMBER → RED=11 and Done=1 next cycle, GRN never set; NewRace=1 → IDLE, all lamps 0.
- Async reset: Rst=0 during step 2 → all outputs 0 without a clock edge; after release the race restarts from IDLE. With DRAG_REACTION_TIMER_EN: lane 1 drops SB 3 cycles after green → React[1]=3, Winner=10.

Source files
------------

// File: rtl/drag_pkg.sv
// rtl/drag_pkg.sv - shared state encoding and tree-mode constants for the drag tree controller
//
// Contents:
//   drag_state_e : 3-bit controller state (IDLE, STAGE, AMBER, GREEN, DONE)
//   FULL_TREE    : ambers light one at a time
//   PRO_TREE     : all ambers light together for a single step
package drag_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STAGE = 3'd1,
    AMBER = 3'd2,
    GREEN = 3'd3,
    DONE  = 3'd4
  } drag_state_e;

  localparam logic FULL_TREE = 1'b0;
  localparam logic PRO_TREE  = 1'b1;

endpackage

// File: rtl/drag_interval_timer.sv
// rtl/drag_interval_timer.sv - shared up-counter with synchronous clear and terminal-count compare
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, counter returns to 0
//   clr   : synchronous clear, wins over en
//   en    : count enable
//   term  : terminal count value to compare against
//   tc    : 1 while the current count equals term (equality only, no wrap handling)
module drag_interval_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/drag_tree_ctrl.sv
// rtl/drag_tree_ctrl.sv - N-lane drag-race christmas tree controller (staging, amber countdown, green/foul result)
//
// Optional feature macro: DRAG_REACTION_TIMER_EN (adds React and Winner outputs).
//
// Ports:
//   Clock   : system clock
//   Rst     : asynchronous active-low reset
//   ProMode : 0 = full tree, 1 = pro tree; latched while IDLE
//   NewRace : returns DONE to IDLE, clearing the result
//   PSB/SB  : pre-stage / stage beams per lane, 1 = broken
//   PSL/SL  : registered copies of PSB/SB
//   AMB     : shared amber lamps, AMB[0] is the top lamp
//   GRN/RED : per-lane green / foul lamps
//   React   : (feature) per-lane reaction cycle count, CNT_W bits per lane
//   Winner  : (feature) one-hot first non-fouled lane to leave
//   Done    : race result latched (GREEN and DONE)
module drag_tree_ctrl
  import drag_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int AMBERS       = 3,
  parameter int STAGE_CYCLES = 50000000,
  parameter int STEP_CYCLES  = 25000000,
  parameter int CNT_W        = 26
) (
  input  logic                   Clock,
  input  logic                   Rst,
  input  logic                   ProMode,
  input  logic                   NewRace,
  input  logic [LANES-1:0]       PSB,
  input  logic [LANES-1:0]       SB,
  output logic [LANES-1:0]       PSL,
  output logic [LANES-1:0]       SL,
  output logic [AMBERS-1:0]      AMB,
  output logic [LANES-1:0]       GRN,
  output logic [LANES-1:0]       RED,
`ifdef DRAG_REACTION_TIMER_EN
  output logic [LANES*CNT_W-1:0] React,
  output logic [LANES-1:0]       Winner,
`endif
  output logic                   Done
);

  localparam logic [CNT_W-1:0]  STAGE_TC  = CNT_W'(STAGE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STEP_TC   = CNT_W'(STEP_CYCLES - 1);
  localparam logic [1:0]        LAST_STEP = 2'(AMBERS - 1);
  localparam logic [AMBERS-1:0] AMB_ONE   = AMBERS'(1);

  drag_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic [1:0]        step_q, step_d;
  logic [LANES-1:0]  foul_q, foul_d;
  logic [LANES-1:0]  psl_q, psl_d;
  logic [LANES-1:0]  sl_q, sl_d;
  logic [AMBERS-1:0] amb_q, amb_d;
  logic [LANES-1:0]  grn_q, grn_d;
  logic [LANES-1:0]  red_q, red_d;
  logic              done_q, done_d;

  logic              tmr_clr;
  logic              tmr_en;
  logic [CNT_W-1:0]  tmr_term;
  logic              tmr_tc;

`ifdef DRAG_REACTION_TIMER_EN
  logic [LANES*CNT_W-1:0] react_q, react_d;
  logic [LANES-1:0]       winner_q, winner_d;
  logic [LANES-1:0]       frozen_q, frozen_d;
  logic [LANES-1:0]       react_drop;
`endif

  // One timer serves both intervals; the terminal count follows the state.
  drag_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (Clock),
    .rst_n (Rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    step_d   = step_q;
    foul_d   = foul_q;
    psl_d    = PSB;
    sl_d     = SB;
    amb_d    = amb_q;
    grn_d    = grn_q;
    red_d    = red_q;
    done_d   = done_q;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
    tmr_term = (state_q == AMBER) ? STEP_TC : STAGE_TC;

`ifdef DRAG_REACTION_TIMER_EN
    react_d    = react_q;
    winner_d   = winner_q;
    frozen_d   = frozen_q;
    react_drop = '0;
    // Live lanes count while still staged after green and freeze on the first SB fall.
    if ((state_q == GREEN) || (state_q == DONE)) begin
      for (int l = 0; l < LANES; l++) begin
        if (!foul_q[l] && !frozen_q[l]) begin
          if (!SB[l]) begin
            frozen_d[l]   = 1'b1;
            react_drop[l] = 1'b1;
          end else if (react_q[l*CNT_W +: CNT_W] != '1) begin
            react_d[l*CNT_W +: CNT_W] = react_q[l*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
      end
    end
    // Lowest set bit of the drop mask breaks ties toward lane 0.
    if ((winner_q == '0) && (react_drop != '0)) begin
      winner_d = react_drop & (~react_drop + LANES'(1));
    end
`endif

    case (state_q)
      IDLE: begin
        mode_d = ProMode;
        step_d = 2'd0;
        if (&SB) begin
          state_d = STAGE;
        end
      end

      STAGE: begin
        if (!(&SB)) begin
          state_d = IDLE;
        end else if (tmr_tc) begin
          state_d = AMBER;
          step_d  = 2'd0;
          amb_d   = (mode_q == PRO_TREE) ? '1 : AMB_ONE;
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end

      AMBER: begin
        // foul_d includes this cycle's drops, so a drop on the last amber cycle
        // is already excluded from the green mask below.
        foul_d = foul_q | ~SB;
        red_d  = foul_d;
        if (&foul_d) begin
          state_d = DONE;
          amb_d   = '0;
          done_d  = 1'b1;
        end else if (tmr_tc) begin
          if ((mode_q == PRO_TREE) || (step_q == LAST_STEP)) begin
            state_d = GREEN;
            amb_d   = '0;
            grn_d   = ~foul_d;
            done_d  = 1'b1;
          end else begin
            step_d = step_q + 2'd1;
            amb_d  = AMB_ONE << (step_q + 2'd1);
          end
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
        end
      end

      GREEN: begin
        state_d = DONE;
      end

      DONE: begin
        if (NewRace) begin
          state_d = IDLE;
          grn_d   = '0;
          red_d   = '0;
          foul_d  = '0;
          done_d  = 1'b0;
`ifdef DRAG_REACTION_TIMER_EN
          react_d  = '0;
          winner_d = '0;
          frozen_d = '0;
`endif
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q  <= IDLE;
      mode_q   <= FULL_TREE;
      step_q   <= 2'd0;
      foul_q   <= '0;
      psl_q    <= '0;
      sl_q     <= '0;
      amb_q    <= '0;
      grn_q    <= '0;
      red_q    <= '0;
      done_q   <= 1'b0;
`ifdef DRAG_REACTION_TIMER_EN
      react_q  <= '0;
      winner_q <= '0;
      frozen_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      step_q   <= step_d;
      foul_q   <= foul_d;
      psl_q    <= psl_d;
      sl_q     <= sl_d;
      amb_q    <= amb_d;
      grn_q    <= grn_d;
      red_q    <= red_d;
      done_q   <= done_d;
`ifdef DRAG_REACTION_TIMER_EN
      react_q  <= react_d;
      winner_q <= winner_d;
      frozen_q <= frozen_d;
`endif
    end
  end

  assign PSL  = psl_q;
  assign SL   = sl_q;
  assign AMB  = amb_q;
  assign GRN  = grn_q;
  assign RED  = red_q;
  assign Done = done_q;
`ifdef DRAG_REACTION_TIMER_EN
  assign React  = react_q;
  assign Winner = winner_q;
`endif

endmodule

// File: tb/tb_drag_tree_ctrl.sv
// tb/tb_drag_tree_ctrl.sv - directed self-checking bench for drag_tree_ctrl (2 lanes, 3 ambers, short intervals)
module tb_drag_tree_ctrl;

  localparam int LANES        = 2;
  localparam int AMBERS       = 3;
  localparam int STAGE_CYCLES = 8;
  localparam int STEP_CYCLES  = 4;
  localparam int CNT_W        = 8;

  logic                   Clock = 1'b0;
  logic                   Rst;
  logic                   ProMode;
  logic                   NewRace;
  logic [LANES-1:0]       PSB;
  logic [LANES-1:0]       SB;
  logic [LANES-1:0]       PSL;
  logic [LANES-1:0]       SL;
  logic [AMBERS-1:0]      AMB;
  logic [LANES-1:0]       GRN;
  logic [LANES-1:0]       RED;
  logic                   Done;
`ifdef DRAG_REACTION_TIMER_EN
  logic [LANES*CNT_W-1:0] React;
  logic [LANES-1:0]       Winner;
`endif

  int assert_cnt = 0;
  int fail_cnt   = 0;

  always #5 Clock = ~Clock;

  drag_tree_ctrl #(
    .LANES        (LANES),
    .AMBERS       (AMBERS),
    .STAGE_CYCLES (STAGE_CYCLES),
    .STEP_CYCLES  (STEP_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .Clock   (Clock),
    .Rst     (Rst),
    .ProMode (ProMode),
    .NewRace (NewRace),
    .PSB     (PSB),
    .SB      (SB),
    .PSL     (PSL),
    .SL      (SL),
    .AMB     (AMB),
    .GRN     (GRN),
    .RED     (RED),
`ifdef DRAG_REACTION_TIMER_EN
    .React   (React),
    .Winner  (Winner),
`endif
    .Done    (Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  // Full-tree amber pattern by race cycle (cycle 0 = IDLE with SB all staged).
  function automatic logic [31:0] full_amb(input int c);
    if (c >= 9 && c <= 12)  return 32'h1;
    if (c >= 13 && c <= 16) return 32'h2;
    if (c >= 17 && c <= 20) return 32'h4;
    return 32'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst     = 1'b0;
    ProMode = 1'b0;
    NewRace = 1'b0;
    PSB     = 2'b11;
    SB      = 2'b00;
    #3;
    check("rst_amb",  AMB,  0);
    check("rst_grn",  GRN,  0);
    check("rst_red",  RED,  0);
    check("rst_done", Done, 0);
    check("rst_psl",  PSL,  0);
    tick(2);
    check("rst_hold_psl", PSL, 0);
    Rst = 1'b1;
    PSB = 2'b00;
    tick(1);

    // Full tree, clean start.
    ProMode = 1'b0;
    PSB     = 2'b11;
    SB      = 2'b11;
    check("psl_before", PSL, 0);
    for (int c = 1; c <= 21; c++) begin
      tick(1);
      if (c == 1) begin
        check("psl_lat", PSL, 3);
        check("sl_lat",  SL,  3);
      end
      check($sformatf("full_amb_c%0d", c), AMB, full_amb(c));
      check($sformatf("full_done_c%0d", c), Done, (c == 21) ? 1 : 0);
      check($sformatf("full_grn_c%0d", c), GRN, (c == 21) ? 3 : 0);
    end
    tick(1);
    check("full_done_hold_grn", GRN, 3);
    check("full_done_hold", Done, 1);

    // NewRace back to IDLE; ProMode=1 latched in that IDLE cycle.
    NewRace = 1'b1;
    ProMode = 1'b1;
    tick(1);
    NewRace = 1'b0;
    check("newrace_grn", GRN, 0);
    check("newrace_done", Done, 0);

    // Pro tree; mode flip mid-race must be ignored.
    for (int c = 1; c <= 13; c++) begin
      tick(1);
      check($sformatf("pro_amb_c%0d", c), AMB, (c >= 9 && c <= 12) ? 7 : 0);
      check($sformatf("pro_grn_c%0d", c), GRN, (c == 13) ? 3 : 0);
      if (c == 5) ProMode = 1'b0;
    end
    tick(1);
    NewRace = 1'b1;
    SB      = 2'b00;
    tick(1);
    NewRace = 1'b0;
    check("pro_clear_grn", GRN, 0);

    // Staging abort after 5 staged cycles.
    SB = 2'b11;
    tick(5);
    SB = 2'b10;
    tick(1);
    check("abort_amb", AMB, 0);

    // Re-stage: full 8-cycle count, then single foul on lane 0 in step 1.
    SB = 2'b11;
    for (int c = 1; c <= 21; c++) begin
      tick(1);
      check($sformatf("foul_amb_c%0d", c), AMB, full_amb(c));
      check($sformatf("foul_red_c%0d", c), RED, (c >= 15) ? 1 : 0);
      if (c == 14) SB = 2'b10;
      if (c == 16) SB = 2'b11;
    end
    check("foul_grn", GRN, 2);
    check("foul_done", Done, 1);
    tick(1);
    NewRace = 1'b1;
    tick(1);
    NewRace = 1'b0;
    check("foul_clear_red", RED, 0);

    // Lane 1 drops on the final amber cycle: RED only.
    for (int c = 1; c <= 21; c++) begin
      tick(1);
      if (c == 20) begin
        check("last_red_c20", RED, 0);
        SB = 2'b01;
      end
    end
    check("last_grn", GRN, 1);
    check("last_red", RED, 2);
    tick(1);
    NewRace = 1'b1;
    SB      = 2'b11;
    tick(1);
    NewRace = 1'b0;

    // Double foul in step 0.
    tick(10);
    check("dbl_amb_pre", AMB, 1);
    SB = 2'b00;
    tick(1);
    check("dbl_red",  RED,  3);
    check("dbl_done", Done, 1);
    check("dbl_amb",  AMB,  0);
    check("dbl_grn",  GRN,  0);
    tick(1);
    check("dbl_grn_hold", GRN, 0);
    check("dbl_red_hold", RED, 3);
    NewRace = 1'b1;
    tick(1);
    NewRace = 1'b0;
    check("dbl_clr_red",  RED,  0);
    check("dbl_clr_grn",  GRN,  0);
    check("dbl_clr_amb",  AMB,  0);
    check("dbl_clr_done", Done, 0);

    // Async reset during amber step 2.
    SB = 2'b11;
    tick(18);
    check("ar_amb_pre", AMB, 4);
    #2;
    Rst = 1'b0;
    #1;
    check("ar_amb",  AMB, 0);
    check("ar_psl",  PSL, 0);
    check("ar_sl",   SL,  0);
    check("ar_done", Done, 0);
    #1;
    Rst = 1'b1;
    tick(8);
    check("ar_restart_c8", AMB, 0);
    tick(1);
    check("ar_restart_c9", AMB, 1);
    tick(12);
    check("ar_grn_c21", GRN, 3);

`ifdef DRAG_REACTION_TIMER_EN
    tick(3);
    SB = 2'b01;
    tick(1);
    check("react_l1", React[CNT_W +: CNT_W], 3);
    check("react_l0", React[0 +: CNT_W], 4);
    check("winner", Winner, 2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
